gpio_irq_pio: RTL and testbench
===============================

GPIO_IRQ_PIO -- requirements
Module: gpio_irq_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 32: channel count, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..4.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16: stable-sample count, used only with the debounce macro, legal range 2..65535.
REQ-004 SHALL have port clk, input, 1: clock; all logic on posedge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port address, input, 3: register word address.
REQ-007 SHALL have port chipselect, input, 1: slave select.
REQ-008 SHALL have port write_n, input, 1: active-low write strobe, qualified by chipselect.
REQ-009 SHALL have port writedata, input, 32: write data; bits above WIDTH-1 ignored.
REQ-010 SHALL have port readdata, output, 32: registered read data, zero-extended above WIDTH-1.
REQ-011 SHALL have port in_port, input, WIDTH: asynchronous pin inputs.
REQ-012 SHALL have port out_port, output, WIDTH: output data register.
REQ-013 SHALL have port out_en, output, WIDTH: per-pin output enable (1 = drive).
REQ-014 SHALL have port irq, output, 1: registered level interrupt.

Function
REQ-015 Register map: 0 DATA, 1 DIR, 2 IRQ_MASK, 3 EDGE_CAP, 4 OUTSET, 5 OUTCLR, 6 RISE_EN, 7 FALL_EN.
REQ-016 The block SHALL register readdata every cycle from address, giving 1-cycle read latency independent of chipselect.
REQ-017 Reads SHALL return: DATA = conditioned input; DIR, IRQ_MASK, EDGE_CAP, RISE_EN, FALL_EN = register value; OUTSET/OUTCLR = out_port.
REQ-018 Write strobe = chipselect & ~write_n; DATA write loads out_port; OUTSET ORs writedata into out_port; OUTCLR clears the bits of out_port set in writedata; DIR, IRQ_MASK, RISE_EN and FALL_EN writes load the register.
REQ-019 out_en SHALL equal DIR; out_port SHALL be driven regardless of DIR.
REQ-020 in_port[i] SHALL pass through SYNC_STAGES flops; conditioned input = last stage (or debounced value, see REQ-029); prev = conditioned input delayed one cycle.
REQ-021 edge[i] = (RISE_EN[i] & cond[i] & ~prev[i]) | (FALL_EN[i] & ~cond[i] & prev[i]); RISE_EN and FALL_EN both set = any edge.
REQ-022 EDGE_CAP[i] SHALL set the cycle after edge[i]; a write to EDGE_CAP SHALL clear each bit where writedata is 1 (W1C); bits written 0 SHALL be unaffected.
REQ-023 If a W1C hit and a new edge on the same bit occur in the same cycle, the edge SHALL win and the bit stays 1.
REQ-024 irq SHALL register |(EDGE_CAP & IRQ_MASK), lagging EDGE_CAP by 1 cycle; edge to irq latency = 2 cycles after the conditioned input changes.
REQ-025 After reset deassertion, edge detection SHALL be suppressed for SYNC_STAGES+1 cycles, by a saturating counter, so reset-value flushing produces no captures.

Reset
REQ-026 On reset_n low, out_port, DIR, IRQ_MASK, EDGE_CAP, RISE_EN, readdata, irq, synchroniser flops and the suppress counter SHALL clear to 0, immediately and asynchronously.
REQ-027 On reset, FALL_EN SHALL reset to all ones, giving a falling-edge capture default.
REQ-028 Reset asserted mid-debounce SHALL clear all debounce counters and stable values to 0.

Configuration
REQ-029 With GPIO_IRQ_PIO_DEBOUNCE_EN defined, each channel SHALL update its conditioned input only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch break SHALL restart the count.
REQ-030 Without GPIO_IRQ_PIO_DEBOUNCE_EN, the conditioned input SHALL be the synchroniser output and no counters SHALL be synthesised.

Structure
REQ-031 Package gpio_irq_pio_pkg SHALL hold the address constants ADDR_DATA..ADDR_FALL_EN and the default reset value of FALL_EN.
REQ-032 Sub-module gpio_debounce (one channel: counter plus stable flop, parameter DEBOUNCE_CYCLES) SHALL be instantiated WIDTH times via generate under the macro.

Verification
REQ-033 Scenario: write DATA=0x0000_00F0, then OUTSET 0x0F, then OUTCLR 0x30 -> out_port = 0xCF; reading address 0 returns the input, not 0xCF.
REQ-034 Scenario: in_port[3] drops 1->0 with reset defaults -> EDGE_CAP=0x8 exactly SYNC_STAGES+1 cycles later; a rise on [3] produces no capture.
REQ-035 Scenario: IRQ_MASK=0x8 and capture on bit 3 -> irq=1 one cycle after the capture; W1C write 0x8 -> irq=0 two cycles after the write.
REQ-036 Scenario: W1C 0x8 in the same cycle a new bit-3 edge is captured -> EDGE_CAP[3] remains 1.
REQ-037 Scenario: RISE_EN=FALL_EN=0x1 with a pulse on in_port[0] -> both edges captured; in_port held at 0xFFFFFFFF through reset release -> EDGE_CAP stays 0.
REQ-038 Scenario: with debounce enabled, DEBOUNCE_CYCLES=4 and a 3-cycle glitch -> no capture; a 5-cycle level -> one capture.

Source files
------------

// File: rtl/gpio_irq_pio_pkg.sv
// Shared register map and reset constants for the gpio_irq_pio block.
package gpio_irq_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd6;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd7;

  // Falling-edge capture on every pin out of reset.
  localparam logic [31:0] FALL_EN_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/gpio_debounce.sv
// One-channel debouncer: the output follows the input only after it has
// disagreed with the held value for DEBOUNCE_CYCLES consecutive cycles.
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam logic [15:0] RELOAD = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] cnt;
  logic        stable;

  // Down-counter reloads on any agreement, so a broken mismatch run restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (din == stable) begin
      cnt <= RELOAD;
    end else if (cnt == 16'd0) begin
      stable <= din;
      cnt    <= RELOAD;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

  assign dout = stable;

endmodule

// File: rtl/gpio_irq_pio.sv
// GPIO with output set/clear, per-pin direction and edge-capture interrupt.
// Optional per-pin debounce is built when GPIO_IRQ_PIO_DEBOUNCE_EN is defined.
module gpio_irq_pio
  import gpio_irq_pio_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  localparam logic [2:0] SUP_MAX = 3'(SYNC_STAGES + 1);

  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_param_err
    $error("gpio_irq_pio: parameter out of legal range");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] cond;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [2:0]       sup_cnt;
  logic             det_en;
  logic             wr_en;
  logic [31:0]      rd_next;

  assign wr_en   = chipselect & ~write_n;
  assign wr_bits = writedata[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

`ifdef GPIO_IRQ_PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (sync_q[SYNC_STAGES-1][i]),
      .dout    (cond[i])
    );
  end
`else
  assign cond = sync_q[SYNC_STAGES-1];
`endif

  // Hold off detection while the reset zeros flush out of the synchroniser.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sup_cnt <= '0;
    end else if (sup_cnt != SUP_MAX) begin
      sup_cnt <= sup_cnt + 3'd1;
    end
  end

  assign det_en = (sup_cnt == SUP_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= '0;
    else          prev <= cond;
  end

  assign edge_hit = det_en ? ((rise_q & cond & ~prev) | (fall_q & ~cond & prev))
                           : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      dir_q  <= '0;
      mask_q <= '0;
      rise_q <= '0;
      fall_q <= FALL_EN_RST[WIDTH-1:0];
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:     data_q <= wr_bits;
        ADDR_DIR:      dir_q  <= wr_bits;
        ADDR_IRQ_MASK: mask_q <= wr_bits;
        ADDR_OUTSET:   data_q <= data_q | wr_bits;
        ADDR_OUTCLR:   data_q <= data_q & ~wr_bits;
        ADDR_RISE_EN:  rise_q <= wr_bits;
        ADDR_FALL_EN:  fall_q <= wr_bits;
        default: ;
      endcase
    end
  end

  assign cap_clr = (wr_en && address == ADDR_EDGE_CAP) ? wr_bits : '0;

  // A new edge is ORed in after the clear so it survives a same-cycle W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cap_q <= '0;
    else          cap_q <= (cap_q & ~cap_clr) | edge_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |(cap_q & mask_q);
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:     rd_next[WIDTH-1:0] = cond;
      ADDR_DIR:      rd_next[WIDTH-1:0] = dir_q;
      ADDR_IRQ_MASK: rd_next[WIDTH-1:0] = mask_q;
      ADDR_EDGE_CAP: rd_next[WIDTH-1:0] = cap_q;
      ADDR_OUTSET:   rd_next[WIDTH-1:0] = data_q;
      ADDR_OUTCLR:   rd_next[WIDTH-1:0] = data_q;
      ADDR_RISE_EN:  rd_next[WIDTH-1:0] = rise_q;
      ADDR_FALL_EN:  rd_next[WIDTH-1:0] = fall_q;
      default:       rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign out_port = data_q;
  assign out_en   = dir_q;

endmodule

// File: tb/tb_gpio_irq_pio.sv
// Directed bench for gpio_irq_pio: register access, edge capture timing,
// W1C/edge collision, irq latency, reset behaviour, optional debounce.
module tb_gpio_irq_pio;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] in_port;
  logic [31:0] out_port;
  logic [31:0] out_en;
  logic        irq;

  int passed = 0;
  int total  = 0;

  gpio_irq_pio #(
    .WIDTH           (32),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .out_en     (out_en),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_check(input logic [2:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    address = a;
    @(negedge clk);
    check(tag, readdata, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 32'hFFFF_FFFF;

    #3;
    check("rst_out_port", out_port, 32'h0);
    check("rst_out_en",   out_en,   32'h0);
    check("rst_irq",      {31'h0, irq}, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    cycles(3);
    reset_n = 1'b1;
    cycles(12);

    rd_check(3'd3, 32'h0,         "no_cap_after_reset");
    rd_check(3'd7, 32'hFFFF_FFFF, "fall_en_default");
    rd_check(3'd6, 32'h0,         "rise_en_default");

    // Output data register: load, set, clear.
    wr(3'd0, 32'h0000_00F0);
    check("data_load", out_port, 32'h0000_00F0);
    wr(3'd4, 32'h0000_000F);
    check("outset", out_port, 32'h0000_00FF);
    wr(3'd5, 32'h0000_0030);
    check("outclr", out_port, 32'h0000_00CF);
    rd_check(3'd0, 32'hFFFF_FFFF, "data_reads_input");
    rd_check(3'd5, 32'h0000_00CF, "outclr_reads_out");
    wr(3'd1, 32'h0000_0055);
    check("out_en_dir", out_en, 32'h0000_0055);
    check("out_port_indep_dir", out_port, 32'h0000_00CF);
    rd_check(3'd1, 32'h0000_0055, "dir_read");

`ifndef GPIO_IRQ_PIO_DEBOUNCE_EN
    // Fall on bit 3: captured at the 3rd posedge, seen on readdata one later.
    @(negedge clk);
    address = 3'd3;
    in_port = 32'hFFFF_FFF7;
    cycles(3);
    check("cap_not_yet", readdata, 32'h0);
    cycles(1);
    check("cap_fall3", readdata, 32'h0000_0008);
    wr(3'd3, 32'h0000_0008);
    rd_check(3'd3, 32'h0, "w1c_clears");
    @(negedge clk);
    in_port = 32'hFFFF_FFFF;
    cycles(6);
    rd_check(3'd3, 32'h0, "rise_ignored_default");

    // irq: one cycle behind EDGE_CAP; cleared two cycles after W1C.
    wr(3'd2, 32'h0000_0008);
    @(negedge clk);
    in_port = 32'hFFFF_FFF7;
    cycles(3);
    check("irq_not_yet", {31'h0, irq}, 32'h0);
    cycles(1);
    check("irq_set", {31'h0, irq}, 32'h1);
    wr(3'd3, 32'h0000_0008);
    check("irq_hold_after_w1c", {31'h0, irq}, 32'h1);
    cycles(1);
    check("irq_clear", {31'h0, irq}, 32'h0);

    // W1C colliding with a fresh capture on the same bit.
    wr(3'd6, 32'h0000_0008);
    in_port = 32'hFFFF_FFFF;
    cycles(2);
    address    = 3'd3;
    writedata  = 32'h0000_0008;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cycles(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    rd_check(3'd3, 32'h0000_0008, "edge_beats_w1c");
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd2, 32'h0);
    rd_check(3'd3, 32'h0, "cap_cleared_all");

    // Both edges on bit 0; bit 1 fall ignored once FALL_EN narrowed.
    wr(3'd6, 32'h0000_0001);
    wr(3'd7, 32'h0000_0001);
    in_port = 32'hFFFF_FFFE;
    cycles(4);
    rd_check(3'd3, 32'h0000_0001, "any_edge_fall");
    wr(3'd3, 32'h0000_0001);
    in_port = 32'hFFFF_FFFF;
    cycles(4);
    rd_check(3'd3, 32'h0000_0001, "any_edge_rise");
    wr(3'd3, 32'h0000_0001);
    in_port = 32'hFFFF_FFFD;
    cycles(4);
    rd_check(3'd3, 32'h0, "fall_en_narrowed");
    in_port = 32'hFFFF_FFFF;
    cycles(4);
`else
    // Debounce of 4: a 3-cycle glitch is filtered, a 5-cycle level passes.
    @(negedge clk);
    in_port = 32'hFFFF_FFF7;
    cycles(3);
    in_port = 32'hFFFF_FFFF;
    cycles(12);
    rd_check(3'd3, 32'h0, "glitch_filtered");
    in_port = 32'hFFFF_FFF7;
    cycles(5);
    in_port = 32'hFFFF_FFFF;
    cycles(12);
    rd_check(3'd3, 32'h0000_0008, "level_captured");
`endif

    // Asynchronous reset mid-cycle, then release with inputs held high.
    rd_check(3'd4, 32'h0000_00CF, "out_before_reset");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_out_port", out_port, 32'h0);
    check("async_out_en",   out_en,   32'h0);
    check("async_readdata", readdata, 32'h0);
    in_port = 32'hFFFF_FFFF;
    cycles(3);
    reset_n = 1'b1;
    cycles(12);
    rd_check(3'd3, 32'h0,         "cap_after_rerelease");
    rd_check(3'd7, 32'hFFFF_FFFF, "fall_en_reset_again");
    rd_check(3'd6, 32'h0,         "rise_en_reset_again");
    rd_check(3'd2, 32'h0,         "mask_reset");
    check("irq_after_rerelease", {31'h0, irq}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
